// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the write-side data-bus down-sequencer:
//   - target bus width encodings (W8/W16/W32/W64)
//   - sequencer state enumeration
//   - beat_bytes(): number of phrase bytes carried by one beat at a given width
// -----------------------------------------------------------------------------
package dbus_pkg;

    localparam logic [1:0] W8  = 2'd0;
    localparam logic [1:0] W16 = 2'd1;
    localparam logic [1:0] W32 = 2'd2;
    localparam logic [1:0] W64 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        BEAT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [3:0] beat_bytes(input logic [1:0] width);
        logic [3:0] bytes;
        case (width)
            W8:      bytes = 4'd1;
            W16:     bytes = 4'd2;
            W32:     bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/dbus_beat_sel.sv
// -----------------------------------------------------------------------------
// dbus_beat_sel
// Combinational beat decoder. For beat index k at the given bus width it
// produces the down-mux select (byte offset of the beat), the beat's byte
// enables shifted down to lane 0, and a flag marking the final beat of the
// phrase.
//
// Ports
//   i_k      in  3  beat index within the phrase
//   i_width  in  2  bus width code (W8/W16/W32/W64)
//   i_be     in  8  latched phrase byte enables
//   o_dmuxd  out 3  byte offset of beat k (k * beat size)
//   o_be     out 8  byte enables of beat k, lane-aligned, zero-extended
//   o_last   out 1  beat k is the last beat for this width
// -----------------------------------------------------------------------------
module dbus_beat_sel
    import dbus_pkg::*;
(
    input  logic [2:0] i_k,
    input  logic [1:0] i_width,
    input  logic [7:0] i_be,
    output logic [2:0] o_dmuxd,
    output logic [7:0] o_be,
    output logic       o_last
);

    logic [3:0] w_bytes;
    logic [7:0] w_mask;
    logic [7:0] w_shift;

    assign w_bytes = beat_bytes(i_width);
    // 9-bit intermediate so the 64-bit case (8 bytes) yields a full 0xFF mask
    assign w_mask  = 8'((9'd1 << w_bytes) - 9'd1);

    always_comb begin
        o_dmuxd = 3'd0;
        o_last  = 1'b0;
        case (i_width)
            W8: begin
                o_dmuxd = i_k;
                o_last  = (i_k == 3'd7);
            end
            W16: begin
                o_dmuxd = {i_k[1:0], 1'b0};
                o_last  = (i_k == 3'd3);
            end
            W32: begin
                o_dmuxd = {i_k[0], 2'b00};
                o_last  = (i_k == 3'd1);
            end
            default: begin
                o_dmuxd = 3'd0;
                o_last  = (i_k == 3'd0);
            end
        endcase
    end

    assign w_shift = i_be >> o_dmuxd;
    assign o_be    = w_shift & w_mask;

endmodule

// File: rtl/dbus_down_seq.sv
// -----------------------------------------------------------------------------
// dbus_down_seq
// Write-side beat sequencer in front of the 64-to-32/16/8 down-multiplexer.
// A 64-bit phrase with byte enables is accepted in IDLE and split into beats
// of the target bus width. Beats whose byte enables are all zero are skipped
// (one SCAN cycle each, no strobe). Each issued beat holds its strobe, select
// and byte enables for at least cfg_wait+1 cycles and until acknowledged.
//
// Ports
//   sys_clk     in   1       clock, all state changes on rising edge
//   reset       in   1       synchronous active-high reset
//   req_valid   in   1       phrase request valid
//   req_ready   out  1       request can be accepted (IDLE, not in reset)
//   req_data    in   64      phrase data
//   req_be      in   8       phrase byte enables
//   req_width   in   2       bus width: 0=8, 1=16, 2=32, 3=64 bit
//   cfg_wait    in   WAIT_W  wait states per beat, latched on accept
//   phr_data    out  64      registered phrase to the down mux data inputs
//   dmuxd       out  3       down-mux select (byte offset of current beat)
//   bus_strobe  out  1       beat active on the bus
//   bus_be      out  8       lane-aligned byte enables of current beat
//   bus_ack     in   1       bus acknowledge, honoured only during a beat
//   done        out  1       single-cycle pulse at phrase completion
// -----------------------------------------------------------------------------
module dbus_down_seq
    import dbus_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_data,
    input  logic [7:0]        req_be,
    input  logic [1:0]        req_width,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic [63:0]       phr_data,
    output logic [2:0]        dmuxd,
    output logic              bus_strobe,
    output logic [7:0]        bus_be,
    input  logic              bus_ack,
    output logic              done
);

    state_t            r_state;
    logic [63:0]       r_data;
    logic [7:0]        r_be;
    logic [1:0]        r_width;
    logic [WAIT_W-1:0] r_wait;
    logic [2:0]        r_k;
    logic [WAIT_W-1:0] r_wcnt;

    state_t            w_state_nxt;
    logic [2:0]        w_k_nxt;
    logic [WAIT_W-1:0] w_wcnt_nxt;
    logic              w_accept;
    logic [2:0]        w_dmuxd;
    logic [7:0]        w_lane_be;
    logic              w_last;

    dbus_beat_sel u_beat_sel (
        .i_k     (r_k),
        .i_width (r_width),
        .i_be    (r_be),
        .o_dmuxd (w_dmuxd),
        .o_be    (w_lane_be),
        .o_last  (w_last)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_wcnt_nxt  = r_wcnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_k_nxt     = 3'd0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_lane_be == 8'd0) begin
                    // Empty beat: skip it without strobing. The last-beat test
                    // keeps k from running past the end of the phrase.
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_k_nxt = r_k + 3'd1;
                    end
                end else begin
                    w_wcnt_nxt  = r_wait;
                    w_state_nxt = BEAT;
                end
            end
            BEAT: begin
                // Wait states run out first; ack is only honoured at zero.
                if (r_wcnt != '0) begin
                    w_wcnt_nxt = r_wcnt - WAIT_W'(1);
                end else if (bus_ack) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_k_nxt     = r_k + 3'd1;
                        w_state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                w_k_nxt     = 3'd0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and phrase registers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= 64'd0;
            r_be    <= 8'd0;
            r_width <= 2'd0;
            r_wait  <= '0;
            r_k     <= 3'd0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_data  <= req_data;
                r_be    <= req_be;
                r_width <= req_width;
                r_wait  <= cfg_wait;
            end
        end
    end

    assign req_ready  = (r_state == IDLE) && !reset;
    assign phr_data   = r_data;
    assign dmuxd      = w_dmuxd;
    assign bus_strobe = (r_state == BEAT);
    assign bus_be     = bus_strobe ? w_lane_be : 8'd0;
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_dbus_down_seq.sv
module tb_dbus_down_seq;
    import dbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_data;
    logic [7:0]  req_be;
    logic [1:0]  req_width;
    logic [3:0]  cfg_wait;
    logic [63:0] phr_data;
    logic [2:0]  dmuxd;
    logic        bus_strobe;
    logic [7:0]  bus_be;
    logic        bus_ack;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbus_down_seq #(.WAIT_W(4)) dut (
        .sys_clk    (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_be     (req_be),
        .req_width  (req_width),
        .cfg_wait   (cfg_wait),
        .phr_data   (phr_data),
        .dmuxd      (dmuxd),
        .bus_strobe (bus_strobe),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .done       (done)
    );

    // One phrase vector: inputs and hand-computed expectations.
    // dm: expected dmuxd of beat i in nibble i; bbe: expected bus_be of beat i in byte i.
    typedef struct {
        logic [1:0]  width;
        logic [7:0]  be;
        logic [3:0]  wt;
        logic [63:0] data;
        int          n_beats;
        logic [31:0] dm;
        logic [63:0] bbe;
        int          strobe_cyc;
        int          first;
        bit          chk_mux;
        logic [31:0] mux0;
        logic [31:0] mux1;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input logic [1:0] w, input logic [7:0] be, input logic [3:0] wt,
                                input logic [63:0] d, input int n, input logic [31:0] dm,
                                input logic [63:0] bbe, input int sc, input int first,
                                input bit cm, input logic [31:0] m0, input logic [31:0] m1);
        vec_t v;
        v.width = w; v.be = be; v.wt = wt; v.data = d; v.n_beats = n; v.dm = dm;
        v.bbe = bbe; v.strobe_cyc = sc; v.first = first; v.chk_mux = cm;
        v.mux0 = m0; v.mux1 = m1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          c;
        int          beats;
        int          scyc;
        int          first;
        int          unstable;
        bit          fin;
        bit          prev_s;
        logic [2:0]  cur_dm;
        logic [7:0]  cur_be;
        logic [63:0] sh;
        c = 1; beats = 0; scyc = 0; first = -1; unstable = 0; fin = 0; prev_s = 0;
        cur_dm = 3'd0; cur_be = 8'd0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", idx), 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_width = v.width; req_be = v.be; cfg_wait = v.wt;
        req_data = v.data; bus_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_data = 64'd0; req_be = 8'd0; cfg_wait = 4'd0;
        chk($sformatf("v%0d_phr_data", idx), phr_data, v.data);
        while (!fin && c < 200) begin
            if (bus_strobe) begin
                scyc++;
                if (!prev_s) begin
                    if (first < 0) first = c;
                    if (beats < 8) begin
                        chk($sformatf("v%0d_b%0d_dmuxd", idx, beats), 64'(dmuxd), 64'(v.dm[4*beats +: 3]));
                        chk($sformatf("v%0d_b%0d_be", idx, beats), 64'(bus_be), 64'(v.bbe[8*beats +: 8]));
                        if (v.chk_mux && beats < 2) begin
                            sh = phr_data >> (8 * int'(dmuxd));
                            chk($sformatf("v%0d_b%0d_mux", idx, beats), 64'(sh[31:0]),
                                64'((beats == 0) ? v.mux0 : v.mux1));
                        end
                    end
                    beats++;
                    cur_dm = dmuxd;
                    cur_be = bus_be;
                end else if (dmuxd !== cur_dm || bus_be !== cur_be) begin
                    unstable++;
                end
            end
            prev_s = bus_strobe;
            if (done) fin = 1;
            @(negedge clk);
            c++;
        end
        chk($sformatf("v%0d_done_seen", idx), 64'(fin), 64'd1);
        chk($sformatf("v%0d_done_one_cycle", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d_ready_after", idx), 64'(req_ready), 64'd1);
        chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.n_beats));
        chk($sformatf("v%0d_strobe_cycles", idx), 64'(scyc), 64'(v.strobe_cyc));
        chk($sformatf("v%0d_first_strobe", idx), 64'(first), 64'(v.first));
        chk($sformatf("v%0d_unstable", idx), 64'(unstable), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  found;
        bit  dn;

        tbl[0] = mk(W32, 8'hFF, 4'd0, 64'h1122334455667788, 2, 32'h40, 64'h0F0F, 2, 2, 1'b1, 32'h55667788, 32'h11223344);
        tbl[1] = mk(W8,  8'h81, 4'd0, 64'h0123456789ABCDEF, 2, 32'h70, 64'h0101, 2, 2, 1'b0, 32'h0, 32'h0);
        tbl[2] = mk(W16, 8'hFF, 4'd3, 64'hA5A55A5A0F0FF0F0, 4, 32'h6420, 64'h03030303, 16, 2, 1'b0, 32'h0, 32'h0);
        tbl[3] = mk(W64, 8'h00, 4'd0, 64'hDEADBEEFCAFEF00D, 0, 32'h0, 64'h0, 0, -1, 1'b0, 32'h0, 32'h0);
        tbl[4] = mk(W64, 8'hA5, 4'd2, 64'h0000111122223333, 1, 32'h0, 64'hA5, 3, 2, 1'b0, 32'h0, 32'h0);
        tbl[5] = mk(W16, 8'h30, 4'd1, 64'h8877665544332211, 1, 32'h4, 64'h03, 2, 4, 1'b0, 32'h0, 32'h0);
        tbl[6] = mk(W32, 8'h60, 4'd0, 64'hFEDCBA9876543210, 1, 32'h4, 64'h06, 1, 3, 1'b0, 32'h0, 32'h0);
        tbl[7] = mk(W8,  8'h24, 4'd0, 64'h1111111111111111, 2, 32'h52, 64'h0101, 2, 4, 1'b0, 32'h0, 32'h0);

        reset = 1'b1; req_valid = 1'b0; req_data = 64'd0; req_be = 8'd0;
        req_width = 2'd0; cfg_wait = 4'd0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_strobe", 64'(bus_strobe), 64'd0);
        chk("rst_be", 64'(bus_be), 64'd0);
        chk("rst_dmuxd", 64'(dmuxd), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_phr", phr_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Ack held low with an early ack during the wait count.
        @(negedge clk);
        req_valid = 1'b1; req_width = W32; req_be = 8'hFF; cfg_wait = 4'd1;
        req_data = 64'hCAFEF00DDEADBEEF; bus_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus_strobe) found = 1;
            else @(negedge clk);
        end
        chk("ack_strobe_seen", 64'(found), 64'd1);
        chk("ack_b0_dmuxd", 64'(dmuxd), 64'd0);
        chk("ack_b0_be", 64'(bus_be), 64'h0F);
        bus_ack = 1'b1;
        @(negedge clk);
        chk("ack_early_ignored", 64'(bus_strobe), 64'd1);
        bus_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ack_hold_%0d", i), 64'({bus_strobe, dmuxd, bus_be}), 64'({1'b1, 3'd0, 8'h0F}));
            @(negedge clk);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        chk("ack_beat_ended", 64'(bus_strobe), 64'd0);
        found = 0; dn = 0;
        for (int i = 0; i < 20 && !dn; i++) begin
            if (bus_strobe && !found) begin
                found = 1;
                chk("ack_b1_dmuxd", 64'(dmuxd), 64'd4);
                chk("ack_b1_mux", 64'(32'(phr_data >> (8 * int'(dmuxd)))), 64'hCAFEF00D);
            end
            if (done) dn = 1;
            @(negedge clk);
        end
        chk("ack_b1_seen", 64'(found), 64'd1);
        chk("ack_done", 64'(dn), 64'd1);

        // Reset during beat 1 of an 8-bit phrase.
        @(negedge clk);
        req_valid = 1'b1; req_width = W8; req_be = 8'hFF; cfg_wait = 4'd2;
        req_data = 64'h0102030405060708; bus_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus_strobe && dmuxd == 3'd1) found = 1;
            else @(negedge clk);
        end
        chk("mid_beat1_seen", 64'(found), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_outputs", 64'({req_ready, bus_strobe, dmuxd, bus_be, done}), 64'd0);
        chk("mid_rst_phr", phr_data, 64'd0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || bus_strobe) n++;
        end
        chk("mid_rst_no_activity", 64'(n), 64'd0);
        run_vec(8, tbl[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
